// File: rtl/updown_sweep_ctrl_if.sv
// Control/feedback bundle between a sweep sequencer and its host plus counter.
interface updown_sweep_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    // Host-side job request
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [7:0]       sweeps;
    // Counter feedback
    logic [WIDTH-1:0] count_in;
    // Counter drive
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] din;
    // Job status
    logic             busy;
    logic             done;
    logic             err;
    logic [7:0]       sweeps_done;

    // Host and counter side
    modport master (
        output start, abort, lo, hi, sweeps, count_in,
        input  mode, load, din, busy, done, err, sweeps_done
    );

    // Sequencer side
    modport slave (
        input  start, abort, lo, hi, sweeps, count_in,
        output mode, load, din, busy, done, err, sweeps_done
    );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Sequencer that drives an up/down counter through lo->hi->lo sweeps, then parks it.
// Between jobs the counter is held by reloading the last value it was left at.
module updown_sweep_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               clr,
    updown_sweep_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_UP   = 3'd2,
        S_DOWN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_mode;
    logic             r_load;
    logic [WIDTH-1:0] r_din;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [7:0]       r_sweeps_done;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [7:0]       r_sweeps;

    state_t           w_state;
    logic             w_mode;
    logic             w_load;
    logic [WIDTH-1:0] w_din;
    logic             w_busy;
    logic             w_done;
    logic             w_err;
    logic [7:0]       w_sweeps_done;
    logic [WIDTH-1:0] w_hold;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;
    logic [7:0]       w_sweeps;

    logic [WIDTH-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_cnt_dec;
    logic [WIDTH-1:0] w_hi_m1;
    logic [WIDTH-1:0] w_lo_p1;
    logic [8:0]       w_sweeps_next;
    logic             w_more_sweeps;
    logic             w_job_ok;

    assign w_cnt_inc     = bus.count_in + WIDTH'(1);
    assign w_cnt_dec     = bus.count_in - WIDTH'(1);
    assign w_hi_m1       = r_hi - WIDTH'(1);
    assign w_lo_p1       = r_lo + WIDTH'(1);
    assign w_sweeps_next = 9'({1'b0, r_sweeps_done}) + 9'd1;
    assign w_more_sweeps = w_sweeps_next < 9'({1'b0, r_sweeps});
    assign w_job_ok      = (bus.hi > bus.lo) && (bus.sweeps != 8'd0);

    // State and registered outputs; clr parks everything with the counter at 0
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state       <= S_IDLE;
            r_mode        <= 1'b0;
            r_load        <= 1'b1;
            r_din         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_sweeps_done <= 8'd0;
            r_hold        <= '0;
            r_lo          <= '0;
            r_hi          <= '0;
            r_sweeps      <= 8'd0;
        end else begin
            r_state       <= w_state;
            r_mode        <= w_mode;
            r_load        <= w_load;
            r_din         <= w_din;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_err         <= w_err;
            r_sweeps_done <= w_sweeps_done;
            r_hold        <= w_hold;
            r_lo          <= w_lo;
            r_hi          <= w_hi;
            r_sweeps      <= w_sweeps;
        end
    end

    // Next state and next output values; abort outranks every other transition
    always_comb begin
        w_state       = r_state;
        w_mode        = r_mode;
        w_load        = r_load;
        w_din         = r_din;
        w_done        = 1'b0;
        w_err         = 1'b0;
        w_sweeps_done = r_sweeps_done;
        w_hold        = r_hold;
        w_lo          = r_lo;
        w_hi          = r_hi;
        w_sweeps      = r_sweeps;

        case (r_state)
            S_IDLE: begin
                w_load = 1'b1;
                w_din  = r_hold;
                if (bus.start) begin
                    if (w_job_ok) begin
                        w_lo          = bus.lo;
                        w_hi          = bus.hi;
                        w_sweeps      = bus.sweeps;
                        w_sweeps_done = 8'd0;
                        w_din         = bus.lo;
                        w_state       = S_LOAD;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (bus.abort) begin
                    // Counter takes lo on this edge regardless
                    w_load  = 1'b1;
                    w_din   = r_lo;
                    w_hold  = r_lo;
                    w_state = S_IDLE;
                end else begin
                    w_load  = 1'b0;
                    w_mode  = 1'b1;
                    w_state = S_UP;
                end
            end
            S_UP: begin
                if (bus.abort) begin
                    w_load  = 1'b1;
                    w_din   = w_cnt_inc;
                    w_hold  = w_cnt_inc;
                    w_state = S_IDLE;
                end else if (bus.count_in == w_hi_m1) begin
                    // Counter reaches hi on this edge, then heads down
                    w_mode  = 1'b0;
                    w_state = S_DOWN;
                end
            end
            S_DOWN: begin
                if (bus.abort) begin
                    w_load  = 1'b1;
                    w_din   = w_cnt_dec;
                    w_hold  = w_cnt_dec;
                    w_state = S_IDLE;
                end else if (bus.count_in == w_lo_p1) begin
                    // Counter reaches lo on this edge: one sweep completed
                    w_sweeps_done = w_sweeps_next[7:0];
                    if (w_more_sweeps) begin
                        w_mode  = 1'b1;
                        w_state = S_UP;
                    end else begin
                        w_load  = 1'b1;
                        w_din   = r_lo;
                        w_hold  = r_lo;
                        w_done  = 1'b1;
                        w_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_load  = 1'b1;
                w_din   = r_hold;
                w_state = S_IDLE;
            end
            default: begin
                w_load  = 1'b1;
                w_din   = r_hold;
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state == S_LOAD) || (w_state == S_UP) || (w_state == S_DOWN);
    end

    assign bus.mode        = r_mode;
    assign bus.load        = r_load;
    assign bus.din         = r_din;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.sweeps_done = r_sweeps_done;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: counter model in the loop, expected count
// trajectories built from lo/hi/sweeps arithmetic.
module tb_updown_sweep_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             clr;
    logic [WIDTH-1:0] cnt;
    int               n_checks = 0;
    int               n_err    = 0;

    updown_sweep_ctrl_if #(.WIDTH(WIDTH)) bus ();

    updown_sweep_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The free-running counter being sequenced: clr > load > up/down
    always_ff @(posedge clk or posedge clr) begin
        if (clr)           cnt <= '0;
        else if (bus.load) cnt <= bus.din;
        else if (bus.mode) cnt <= cnt + WIDTH'(1);
        else               cnt <= cnt - WIDTH'(1);
    end
    assign bus.count_in = cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Idle with counter parked at v
    task automatic hold_check(input int v, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk("hold_cnt", cnt, v);
            chk("hold_busy", bus.busy, 0);
            chk("hold_done", bus.done, 0);
            chk("hold_err", bus.err, 0);
            chk("hold_load", bus.load, 1);
        end
    endtask

    // abort_at: -1 none, -2 during LOAD, k>=0 during the cycle showing trajectory index k
    task automatic run_job(input int lo, input int hi, input int sw, input int abort_at,
                           input bit noisy_start);
        int exp_q[$];
        int p;
        int len;
        p = 2 * (hi - lo);
        exp_q.push_back(lo);
        for (int s = 0; s < sw; s++) begin
            for (int v = lo + 1; v <= hi; v++) exp_q.push_back(v);
            for (int v = hi - 1; v >= lo; v--) exp_q.push_back(v);
        end
        len = exp_q.size();

        bus.lo     = WIDTH'(lo);
        bus.hi     = WIDTH'(hi);
        bus.sweeps = 8'(sw);
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        chk("busy_at_load", bus.busy, 1);
        chk("load_at_load", bus.load, 1);
        chk("din_at_load", bus.din, lo);

        if (abort_at == -2) begin
            bus.abort = 1'b1;
            tick();
            bus.abort = 1'b0;
            chk("abort_load_cnt", cnt, lo);
            chk("abort_load_busy", bus.busy, 0);
            chk("abort_load_done", bus.done, 0);
            hold_check(lo, 3);
            return;
        end

        for (int k = 0; k < len; k++) begin
            tick();
            chk("cnt", cnt, exp_q[k]);
            chk("done", bus.done, (k == len - 1) ? 1 : 0);
            chk("busy", bus.busy, (k == len - 1) ? 0 : 1);
            if (k == len - 1) chk("sweeps_done", bus.sweeps_done, sw);
            if (k == abort_at) begin
                bus.start = 1'b0;
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
                chk("abort_cnt", cnt, exp_q[k + 1]);
                chk("abort_busy", bus.busy, 0);
                chk("abort_done", bus.done, 0);
                if (((k + 1) % p) != 0) chk("abort_sweeps_done", bus.sweeps_done, k / p);
                hold_check(exp_q[k + 1], 3);
                return;
            end
            bus.start = (noisy_start && (k < len - 1)) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        bus.start = 1'b0;
        hold_check(lo, 3);
        chk("sweeps_done_after", bus.sweeps_done, sw);
    endtask

    // Rejected start: err pulse, nothing else moves
    task automatic err_case(input int lo, input int hi, input int sw);
        int v;
        v          = int'(cnt);
        bus.lo     = WIDTH'(lo);
        bus.hi     = WIDTH'(hi);
        bus.sweeps = 8'(sw);
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        chk("err_pulse", bus.err, 1);
        chk("err_busy", bus.busy, 0);
        chk("err_cnt", cnt, v);
        tick();
        chk("err_clear", bus.err, 0);
        chk("err_busy2", bus.busy, 0);
        chk("err_cnt2", cnt, v);
    endtask

    initial begin
        int lo;
        int d;
        int sw;

        clr        = 1'b1;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.lo     = '0;
        bus.hi     = '0;
        bus.sweeps = 8'd0;

        // 1: reset state and parked counter
        tick();
        tick();
        chk("rst_cnt", cnt, 0);
        chk("rst_load", bus.load, 1);
        chk("rst_din", bus.din, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mode", bus.mode, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_sweeps_done", bus.sweeps_done, 0);
        @(negedge clk);
        clr = 1'b0;
        hold_check(0, 10);

        // 2, 3: directed jobs
        run_job(3, 6, 2, -1, 1'b0);
        run_job(10, 11, 3, -1, 1'b1);

        // 4: rejected starts
        err_case(5, 5, 2);
        err_case(7, 4, 1);
        err_case(20, 30, 0);

        // 5: abort in UP at count 4 freezes at 5
        run_job(0, 8, 1, 4, 1'b0);
        // abort during LOAD and during DOWN
        run_job(40, 44, 2, -2, 1'b0);
        run_job(40, 44, 2, 6, 1'b0);

        // 6: clr mid-DOWN at count 7
        bus.lo     = WIDTH'(0);
        bus.hi     = WIDTH'(8);
        bus.sweeps = 8'd2;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("pre_clr_cnt", cnt, 7);
        chk("pre_clr_busy", bus.busy, 1);
        #2;
        clr = 1'b1;
        #1;
        chk("clr_cnt", cnt, 0);
        chk("clr_busy", bus.busy, 0);
        chk("clr_load", bus.load, 1);
        chk("clr_din", bus.din, 0);
        chk("clr_mode", bus.mode, 0);
        chk("clr_done", bus.done, 0);
        chk("clr_sweeps_done", bus.sweeps_done, 0);
        @(negedge clk);
        clr = 1'b0;
        hold_check(0, 2);
        run_job(2, 5, 1, -1, 1'b0);

        // Randomized jobs, with stray starts while busy
        repeat (6) begin
            lo = $urandom_range(0, 230);
            d  = $urandom_range(1, 12);
            sw = $urandom_range(1, 3);
            run_job(lo, lo + d, sw, -1, 1'b1);
        end

        // Randomized aborts anywhere inside the job
        repeat (5) begin
            lo = $urandom_range(0, 230);
            d  = $urandom_range(1, 12);
            sw = $urandom_range(1, 3);
            run_job(lo, lo + d, sw, $urandom_range(0, 2 * d * sw - 1), 1'b0);
        end

        // Randomized rejected starts
        repeat (3) begin
            lo = $urandom_range(1, 255);
            err_case(lo, $urandom_range(0, lo), $urandom_range(1, 5));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
